// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - RV64I decode stage with ID/EX register and load-use stall.
// Define ILLEGAL_INST_EN to flag unknown opcodes on id_illegal instead of dropping them as NOPs.
module inst_decode #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] PC_i,
  input  logic            stall,
  input  logic            take_branch,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            hazard_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_PC,
  output logic [3:0]      id_op,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic [4:0]      id_rd,
  output logic            id_reg_write,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic            id_illegal
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_LUI     = 4'd1;
  localparam logic [3:0] OP_AUIPC   = 4'd2;
  localparam logic [3:0] OP_JAL     = 4'd3;
  localparam logic [3:0] OP_JALR    = 4'd4;
  localparam logic [3:0] OP_BRANCH  = 4'd5;
  localparam logic [3:0] OP_LOAD    = 4'd6;
  localparam logic [3:0] OP_STORE   = 4'd7;
  localparam logic [3:0] OP_OPIMM   = 4'd8;
  localparam logic [3:0] OP_OP      = 4'd9;
  localparam logic [3:0] OP_OPIMM32 = 4'd10;
  localparam logic [3:0] OP_OP32    = 4'd11;
  localparam logic [3:0] OP_SYSTEM  = 4'd12;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_known, dec_writes, uses_rs1, uses_rs2;
  logic            dec_valid, dec_reg_write, dec_illegal;

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec_op     = OP_NOP;
    dec_known  = 1'b1;
    dec_writes = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    case (opcode)
      7'b0110111: begin dec_op = OP_LUI;     dec_writes = 1'b1; end
      7'b0010111: begin dec_op = OP_AUIPC;   dec_writes = 1'b1; end
      7'b1101111: begin dec_op = OP_JAL;     dec_writes = 1'b1; end
      7'b1100111: begin dec_op = OP_JALR;    dec_writes = 1'b1; uses_rs1 = 1'b1; end
      7'b1100011: begin dec_op = OP_BRANCH;  uses_rs1 = 1'b1;   uses_rs2 = 1'b1; end
      7'b0000011: begin dec_op = OP_LOAD;    dec_writes = 1'b1; uses_rs1 = 1'b1; end
      7'b0100011: begin dec_op = OP_STORE;   uses_rs1 = 1'b1;   uses_rs2 = 1'b1; end
      7'b0010011: begin dec_op = OP_OPIMM;   dec_writes = 1'b1; uses_rs1 = 1'b1; end
      7'b0110011: begin dec_op = OP_OP;      dec_writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0011011: begin dec_op = OP_OPIMM32; dec_writes = 1'b1; uses_rs1 = 1'b1; end
      7'b0111011: begin dec_op = OP_OP32;    dec_writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0001111: dec_op = OP_SYSTEM;
      7'b1110011: begin
        if (inst[14:12] == 3'd0) dec_op = OP_SYSTEM;
        else dec_known = 1'b0;
      end
      default: dec_known = 1'b0;
    endcase
    // The canonical NOP collapses to class 0 even though it is an OPIMM encoding.
    if (inst == NOP_INST) dec_op = OP_NOP;
  end

  always_comb begin
    case (dec_op)
      OP_LUI, OP_AUIPC: dec_imm = imm_u;
      OP_JAL:           dec_imm = imm_j;
      OP_BRANCH:        dec_imm = imm_b;
      OP_STORE:         dec_imm = imm_s;
      default:          dec_imm = imm_i;
    endcase
  end

`ifdef ILLEGAL_INST_EN
  assign dec_illegal = ~dec_known;
`else
  assign dec_illegal = 1'b0;
`endif

  assign dec_valid     = dec_known ? (inst != NOP_INST) : dec_illegal;
  assign dec_reg_write = dec_known & dec_writes & (rd != 5'd0) & (inst != NOP_INST);

  assign hazard_stall = id_valid & (id_op == OP_LOAD) & id_reg_write &
                        (((id_rd == rs1_addr) & uses_rs1) | ((id_rd == rs2_addr) & uses_rs2)) &
                        ~take_branch;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      id_valid     <= 1'b0;
      id_PC        <= '0;
      id_op        <= OP_NOP;
      id_funct3    <= 3'd0;
      id_funct7b5  <= 1'b0;
      id_rd        <= 5'd0;
      id_reg_write <= 1'b0;
      id_imm       <= '0;
      id_rs1_val   <= '0;
      id_rs2_val   <= '0;
      id_illegal   <= 1'b0;
    end else if (take_branch || (!stall && hazard_stall)) begin
      id_valid     <= 1'b0;
      id_op        <= OP_NOP;
      id_reg_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (!stall) begin
      id_valid     <= dec_valid;
      id_PC        <= PC_i;
      id_op        <= dec_op;
      id_funct3    <= inst[14:12];
      id_funct7b5  <= inst[30];
      id_rd        <= rd;
      id_reg_write <= dec_reg_write;
      id_imm       <= dec_imm;
      id_rs1_val   <= (rs1_addr == 5'd0) ? '0 : rs1_data;
      id_rs2_val   <= (rs2_addr == 5'd0) ? '0 : rs2_data;
      id_illegal   <= dec_illegal;
    end
  end

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
RV64I decode stage sitting directly downstream of the instruction fetch stage. Consumes the fetched 32-bit instruction and its PC, drives the register-file read addresses and classifies the instruction. Produces sign-extended immediates and registers everything into an ID/EX pipeline register. Detects load-use hazards and requests a one-cycle fetch stall with a bubble.

Parameters:
XLEN, 64, datapath width of PC, immediates and operand values
NOP_INST, 32'h00000013, encoding treated as a bubble (addi x0,x0,0)

Ports:
CLK  input  1  pipeline clock, ID/EX register updates on rising edge
reset  input  1  asynchronous active-low reset
inst  input  32  instruction from fetch, stable before rising edge
PC_i  input  XLEN  PC of inst
stall  input  1  downstream (EX/MEM) stall; hold ID/EX contents
take_branch  input  1  branch/jump resolved taken in EX; flush
rs1_addr  output  5  combinational inst[19:15] to register file
rs2_addr  output  5  combinational inst[24:20] to register file
rs1_data  input  XLEN  register-file read data for rs1_addr
rs2_data  input  XLEN  register-file read data for rs2_addr
hazard_stall  output  1  combinational load-use stall request to fetch
id_valid  output  1  ID/EX slot holds a real instruction
id_PC  output  XLEN  registered PC
id_op  output  4  class: 0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 OPIMM32, 11 OP32, 12 SYSTEM/FENCE
id_funct3  output  3  inst[14:12]
id_funct7b5  output  1  inst[30]
id_rd  output  5  destination register
id_reg_write  output  1  writes rd; forced 0 when rd==0
id_imm  output  XLEN  sign-extended immediate for the class
id_rs1_val  output  XLEN  operand 1 (0 when rs1_addr==0)
id_rs2_val  output  XLEN  operand 2 (0 when rs2_addr==0)
id_illegal  output  1  unrecognised opcode (see Optional Feature)

Behaviour:
- Reset (async, reset low): id_valid=0, id_op=0, id_reg_write=0, id_illegal=0; id_PC, id_imm, id_rs1_val, id_rs2_val, id_rd, id_funct3, id_funct7b5 all 0; hazard_stall=0.
- Latency: one cycle, inst sampled at rising edge t and visible on id_* after t.
- Immediates: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}. All are sign-extended from inst[31] to XLEN. NOP/SYSTEM classes use imm=I.
- id_reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, OPIMM32 and OP32 when rd!=0; otherwise 0.
- Load-use hazard: hazard_stall = id_valid & (id_op==LOAD) & id_reg_write & ((id_rd==rs1_addr & class uses rs1) | (id_rd==rs2_addr & class uses rs2)) & !take_branch. Classes using rs2: BRANCH, STORE, OP, OP32.
- Edge priority, highest first:
  1. take_branch: insert a bubble (id_valid=0, id_op=0, id_reg_write=0).
  2. stall: hold all id_* registers.
  3. hazard_stall: insert a bubble. Fetch holds inst, so the same inst re-decodes the next cycle; that cycle the hazard is clear because the bubble is not a load.
  4. Otherwise load the decode of inst with id_valid=1. inst==NOP_INST loads as id_op=0 with id_valid=0.
- take_branch concurrent with stall: flush wins.
- A load followed by an instruction with rd==0 sources reading x0 raises no hazard, because the load's id_reg_write is 0.
- Reset deasserting mid-cycle: first decode is at the next rising edge.

Optional Feature:
ILLEGAL_INST_EN.
- Defined: an opcode outside the listed classes, or a SYSTEM instruction with funct3!=0, registers id_illegal=1 with id_valid=1, id_op=0 and id_reg_write=0. The flag follows the same flush/stall/bubble rules as the other id_* registers.
- Undefined: such instructions decode silently as NOP (id_valid=0), and id_illegal is tied to 0.

Test Plan:
1. Reset low mid-run with valid ID/EX contents -> all id_* outputs 0 immediately, without waiting for a clock edge.
2. inst=32'hFFF00093 (addi x1,x0,-1), PC_i=0x100 -> id_op=8, id_rd=1, id_imm=0xFFFFFFFFFFFFFFFF, id_rs1_val=0, id_reg_write=1, id_PC=0x100.
3. ld x5,0(x2) then add x6,x5,x7 -> hazard_stall=1 for exactly one cycle, one bubble (id_valid=0), then the add decodes with rs1_addr=5.
4. Branch inst=32'hFE000EE3 (beq x0,x0,-4) -> id_op=5, id_imm=0xFFFFFFFFFFFFFFFC, id_reg_write=0.
5. take_branch=1 with stall=1 while a jal is being decoded -> next cycle id_valid=0 and id_reg_write=0. A JAL to x1 with J imm 0x800 then yields id_imm=0x800.
6. stall=1 for 3 cycles during a lui x3,0x12345 -> id_imm holds 0x12345000 and id_valid holds 1 across all 3 cycles. With ILLEGAL_INST_EN defined, inst=0x0000007F -> id_illegal=1.
